// File: rtl/dual_port_ram_clr_if.sv
// rtl/dual_port_ram_clr_if.sv - port bundle for dual_port_ram_clr
//
// Groups the clear/write/read signals of dual_port_ram_clr.
//   clear, busy   : clear request in, clear-engine running out
//   we, wraddr,
//   data, be      : write port with per-byte enables
//   re, rdaddr    : read request
//   q, q_valid    : registered read data and its one-cycle valid pulse
// master = user of the RAM, slave = the RAM itself.
interface dual_port_ram_clr_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int BYTE_WIDTH = 8
);
  localparam int NBE = DATA_WIDTH / BYTE_WIDTH;

  logic                  clear;
  logic                  busy;
  logic                  we;
  logic [ADDR_WIDTH-1:0] wraddr;
  logic [DATA_WIDTH-1:0] data;
  logic [NBE-1:0]        be;
  logic                  re;
  logic [ADDR_WIDTH-1:0] rdaddr;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;

  modport master (
    output clear, we, wraddr, data, be, re, rdaddr,
    input  busy, q, q_valid
  );

  modport slave (
    input  clear, we, wraddr, data, be, re, rdaddr,
    output busy, q, q_valid
  );
endinterface

// File: rtl/dual_port_ram_clr.sv
// rtl/dual_port_ram_clr.sv - 1W/1R RAM with byte enables and built-in clear engine
//
// One write port and one read port sharing a single clock. Writes honour
// per-byte enables; reads are registered with a valid pulse. After reset,
// or when clear is pulsed in IDLE, every word is overwritten with CLEAR_VAL,
// one address per cycle, while busy is high; reads and writes are ignored
// during that time.
//
// Ports:
//   clk    : single clock, all state on the rising edge
//   reset  : asynchronous, active-high
//   bus    : dual_port_ram_clr_if.slave (clear/busy, write port, read port, q/q_valid)
//
// Optional macro RAM_OUT_REG_EN: adds a second output register, making the
// read latency 2 cycles (q and q_valid stay aligned).
module dual_port_ram_clr #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    BYTE_WIDTH = 8,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
  input  logic               clk,
  input  logic               reset,
  dual_port_ram_clr_if.slave bus
);
  localparam int NBE   = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NBE-1:0]        mem_be;

  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [DATA_WIDTH-1:0] q1;
  logic                  q1_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // The clear engine owns the write port while busy; user we/re/clear only
  // take effect in IDLE.
  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    mem_we       = 1'b0;
    mem_addr     = bus.wraddr;
    mem_wdata    = bus.data;
    mem_be       = bus.be;
    rd_en        = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = CLEAR_VAL;
        mem_be    = '1;
        if (clr_addr == LAST_ADDR) begin
          state_nxt    = S_IDLE;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + ADDR_WIDTH'(1);
        end
      end
      default: begin
        mem_we = bus.we;
        rd_en  = bus.re;
        if (bus.clear) begin
          state_nxt    = S_CLEAR;
          clr_addr_nxt = '0;
        end
      end
    endcase
  end

  assign bus.busy = (state == S_CLEAR);

  // No reset on the array. While reset is held the engine sits at address 0
  // and keeps writing CLEAR_VAL there, which the restarted clear redoes anyway.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NBE; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // rd_old is the pre-write word (the array updates after this edge);
  // rd_merged is what the same-address write is about to store.
  always_comb begin
    rd_old    = mem[bus.rdaddr];
    rd_merged = rd_old;
    for (int i = 0; i < NBE; i++) begin
      if (bus.be[i]) begin
        rd_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    rd_word = rd_old;
    if ((RDW_MODE != 0) && bus.we && (bus.wraddr == bus.rdaddr)) begin
      rd_word = rd_merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q1       <= '0;
      q1_valid <= 1'b0;
    end else begin
      q1_valid <= rd_en;
      if (rd_en) begin
        q1 <= rd_word;
      end
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] q2;
  logic                  q2_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q2       <= '0;
      q2_valid <= 1'b0;
    end else begin
      q2       <= q1;
      q2_valid <= q1_valid;
    end
  end

  assign bus.q       = q2;
  assign bus.q_valid = q2_valid;
`else
  assign bus.q       = q1;
  assign bus.q_valid = q1_valid;
`endif

endmodule

// File: doc/dual_port_ram_clr.md
Name: dual_port_ram_clr

Overview:
- Parametrised successor to the team's simple dual-address RAM: one write port and one read port, with per-byte write enables and a registered read output carrying a valid flag.
- Selectable read-during-write behaviour.
- Built-in clear engine walks every address after reset, or on request, writing a fixed value.
- Used as scratch/frame storage in FPGA-flow designs that need known contents without an init file.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of BYTE_WIDTH.
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH words.
- BYTE_WIDTH, 8, bits per byte-enable lane; NBE = DATA_WIDTH/BYTE_WIDTH.
- RDW_MODE, 0, same-address read/write in one cycle: 0 = old data, 1 = new (merged) data.
- CLEAR_VAL, 0, DATA_WIDTH-wide value written by the clear engine.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  request full-memory clear; sampled in IDLE only.
- busy  out  1  high while the clear engine runs.
- we  in  1  write enable.
- wraddr  in  ADDR_WIDTH  write address.
- data  in  DATA_WIDTH  write data.
- be  in  NBE  byte enables; lane i covers data[i*BYTE_WIDTH +: BYTE_WIDTH].
- re  in  1  read enable.
- rdaddr  in  ADDR_WIDTH  read address.
- q  out  DATA_WIDTH  registered read data.
- q_valid  out  1  one-cycle pulse marking a new q.

Behaviour:
- Reset (async assert): state=CLEAR, clr_addr=0, busy=1, q=0, q_valid=0. Memory array is not reset; the clear engine initialises it once reset deasserts.
- FSM states IDLE and CLEAR.
  - CLEAR: on every edge, write CLEAR_VAL to mem[clr_addr] and increment clr_addr.
  - When clr_addr==DEPTH-1 is written, next state is IDLE, busy=0, clr_addr=0.
  - Clear therefore takes exactly DEPTH cycles; busy is high for DEPTH cycles after reset release.
  - IDLE: clear=1 at an edge moves to CLEAR with busy=1 from that edge. we/re sampled at the same edge still execute.
  - clear while in CLEAR is ignored; there is no restart.
- While busy=1: we and re are ignored, q holds its value, q_valid=0.
- Write (IDLE, we=1): for each lane i with be[i]=1, mem[wraddr] lane i <= data lane i. Other lanes are unchanged. be=0 means no change.
- Read latency is 1 cycle. re=1 at edge k gives q=mem[rdaddr] and q_valid=1 after edge k. With re=0, q holds and q_valid=0.
- Same-address read and write at the same edge, re=we=1, rdaddr==wraddr:
  - RDW_MODE=0: q = pre-write word.
  - RDW_MODE=1: q = byte-merged new word (old lanes where be=0).
- Different addresses never interact.
- Addresses wrap naturally (ADDR_WIDTH bits); there is no out-of-range case.
- Reset asserted mid-clear or mid-read aborts immediately. Outputs return to reset values, and a full clear restarts after release.

Optional Feature:
- Macro RAM_OUT_REG_EN.
- Defined: a second output register stage is added; read latency becomes 2. q and q_valid are both delayed one extra cycle and stay aligned. The extra stage resets to 0, and q_valid never asserts for reads issued while busy. RDW_MODE semantics are unchanged.
- Undefined: single-stage output with latency 1, as above.

Test Plan:
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=5, BYTE_WIDTH=8, macro undefined unless stated.
1. Release reset -> busy=1 for exactly 32 cycles, then 0. Read addr 31 -> q=0x0000, q_valid pulse 1 cycle later.
2. Write 0xBEEF to addr 3, be=2'b11; read addr 3 next cycle -> q=0xBEEF with q_valid=1 for one cycle. With re=0 afterwards, q stays 0xBEEF and q_valid=0.
3. Addr 3 holds 0xBEEF; write 0x1234 with be=2'b01 -> read gives 0xBE34. Write 0x5678 with be=2'b00 -> read still gives 0xBE34.
4. Addr 5 holds 0x1111; same edge we=1, re=1, addr 5, data 0x2222, be=2'b11 -> q=0x1111 for RDW_MODE=0 and q=0x2222 for RDW_MODE=1. Repeat RDW_MODE=1 with be=2'b10 -> q=0x2211.
5. After writes, pulse clear in IDLE -> busy high 32 cycles; re issued during busy gives q_valid=0. Afterwards addr 3 and addr 5 read 0x0000.
6. Assert reset 10 cycles into a clear -> busy=1, q=0, q_valid=0 immediately. After release, busy is high 32 more cycles. Repeat test 2 with RAM_OUT_REG_EN defined -> q=0xBEEF and q_valid appear 2 cycles after re.
